// File: rtl/pfa_pkg.sv
// Shared definitions for the PFA (Good-Thomas) address generator:
// default index width and the divider-free modular add.
package pfa_pkg;

    localparam int unsigned PFA_W    = 16;
    localparam int unsigned PFA_WMAX = 32;

    // Compare-subtract modular add; operands are zero-extended to PFA_WMAX bits
    // so the sum carries one guard bit beyond any supported index width.
    function automatic logic [PFA_WMAX-1:0] mod_add(
        input logic [PFA_WMAX-1:0] a,
        input logic [PFA_WMAX-1:0] b,
        input logic [PFA_WMAX-1:0] m
    );
        logic [PFA_WMAX:0] sum;
        logic [PFA_WMAX:0] diff;
        sum  = (PFA_WMAX+1)'(a) + (PFA_WMAX+1)'(b);
        diff = sum - (PFA_WMAX+1)'(m);
        return (sum >= (PFA_WMAX+1)'(m)) ? PFA_WMAX'(diff) : PFA_WMAX'(sum);
    endfunction

endpackage

// File: rtl/pfa_mod_step.sv
// Registered modular accumulator: idx <= (idx + step) mod modulus each enabled cycle,
// forced to zero by clr.
module pfa_mod_step
    import pfa_pkg::*;
#(
    parameter int unsigned wDataInOut = PFA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [wDataInOut-1:0] step,
    input  logic [wDataInOut-1:0] modulus,
    output logic [wDataInOut-1:0] idx
);

    localparam int unsigned W = wDataInOut;

    logic [W-1:0] idx_nxt;

    always_comb begin
        idx_nxt = W'(mod_add(PFA_WMAX'(idx), PFA_WMAX'(step), PFA_WMAX'(modulus)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en) begin
            idx <= idx_nxt;
        end
    end

endmodule

// File: rtl/pfa_addr_trans.sv
// Good-Thomas PFA index generator for N = Nf1*Nf2*Nf3, one (n1,n2,n3) triple per clock.
// Define PFA_ADDR_LINEAR_EN to add the registered linear address output addr.
module pfa_addr_trans
    import pfa_pkg::*;
#(
    parameter int unsigned wDataInOut = PFA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [wDataInOut-1:0] Nf1,
    input  logic [wDataInOut-1:0] Nf2,
    input  logic [wDataInOut-1:0] Nf3,
    input  logic [wDataInOut-1:0] q_p,
    input  logic [wDataInOut-1:0] r_p,
    output logic [wDataInOut-1:0] n1,
    output logic [wDataInOut-1:0] n2,
`ifdef PFA_ADDR_LINEAR_EN
    output logic [wDataInOut-1:0] n3,
    output logic [wDataInOut-1:0] addr
`else
    output logic [wDataInOut-1:0] n3
`endif
);

    localparam int unsigned W = wDataInOut;

    logic [W-1:0] k;
    logic [W-1:0] frame_len;
    logic         wrap;
    logic         restart;

    // Frame length truncated to W bits; k = frame_len-1 marks the last triple.
    assign frame_len = W'(Nf1 * Nf2 * Nf3);
    assign wrap      = (k == (frame_len - W'(1)));
    assign restart   = clr | wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
        end else if (restart) begin
            k <= '0;
        end else begin
            k <= k + W'(1);
        end
    end

    pfa_mod_step #(.wDataInOut(W)) u_step1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (restart),
        .en      (1'b1),
        .step    (W'(1)),
        .modulus (Nf1),
        .idx     (n1)
    );

    pfa_mod_step #(.wDataInOut(W)) u_step2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (restart),
        .en      (1'b1),
        .step    (r_p),
        .modulus (Nf2),
        .idx     (n2)
    );

    pfa_mod_step #(.wDataInOut(W)) u_step3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (restart),
        .en      (1'b1),
        .step    (q_p),
        .modulus (Nf3),
        .idx     (n3)
    );

`ifdef PFA_ADDR_LINEAR_EN
    logic [W-1:0] n1_nxt;
    logic [W-1:0] n2_nxt;
    logic [W-1:0] n3_nxt;
    logic [W-1:0] addr_nxt;

    // Rebuild the next triple so the registered address lands with the indices.
    always_comb begin
        n1_nxt   = '0;
        n2_nxt   = '0;
        n3_nxt   = '0;
        if (!restart) begin
            n1_nxt = W'(mod_add(PFA_WMAX'(n1), PFA_WMAX'(1), PFA_WMAX'(Nf1)));
            n2_nxt = W'(mod_add(PFA_WMAX'(n2), PFA_WMAX'(r_p), PFA_WMAX'(Nf2)));
            n3_nxt = W'(mod_add(PFA_WMAX'(n3), PFA_WMAX'(q_p), PFA_WMAX'(Nf3)));
        end
        addr_nxt = W'(n1_nxt * Nf2 * Nf3 + n2_nxt * Nf3 + n3_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else begin
            addr <= addr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pfa_addr_trans.sv
// Self-checking bench for pfa_addr_trans; checks addr too when PFA_ADDR_LINEAR_EN is defined.
module tb_pfa_addr_trans;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic [W-1:0] Nf1, Nf2, Nf3, q_p, r_p;
    logic [W-1:0] n1, n2, n3;
`ifdef PFA_ADDR_LINEAR_EN
    logic [W-1:0] addr;
`endif

    pfa_addr_trans #(.wDataInOut(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .Nf1   (Nf1),
        .Nf2   (Nf2),
        .Nf3   (Nf3),
        .q_p   (q_p),
        .r_p   (r_p),
        .n1    (n1),
        .n2    (n2),
`ifdef PFA_ADDR_LINEAR_EN
        .n3    (n3),
        .addr  (addr)
`else
        .n3    (n3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: factors, strides and position t within the current frame.
    int f1, f2, f3, qs, rs;
    int t;

    typedef struct {
        int e1;
        int e2;
        int e3;
        int ea;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0d time=%0t)", name, act, exp, t, $time);
        end
    endtask

    function automatic int lin(input int a, input int b, input int c);
        return (a * f2 * f3 + b * f3 + c) & 32'h0000_FFFF;
    endfunction

    task automatic check_triple(input string name, input int e1, input int e2, input int e3);
        check({name, ".n1"}, int'(n1), e1);
        check({name, ".n2"}, int'(n2), e2);
        check({name, ".n3"}, int'(n3), e3);
`ifdef PFA_ADDR_LINEAR_EN
        check({name, ".addr"}, int'(addr), lin(e1, e2, e3));
`endif
    endtask

    // Closed form: after t advances, each index is t times its stride modulo its factor.
    task automatic check_model(input string name);
        check_triple(name, t % f1, (t * rs) % f2, (t * qs) % f3);
    endtask

    task automatic set_cfg(input int a, input int b, input int c, input int q, input int r);
        f1 = a; f2 = b; f3 = c; qs = q; rs = r;
        Nf1 = W'(a); Nf2 = W'(b); Nf3 = W'(c); q_p = W'(q); r_p = W'(r);
    endtask

    // Advance one clock (inputs already driven), update the model, sample at negedge.
    task automatic tick(input string name);
        @(posedge clk);
        if (clr) t = 0;
        else     t = (t + 1) % (f1 * f2 * f3);
        @(negedge clk);
        check_model(name);
    endtask

    // Hold clr for one edge and release it at the following negedge.
    task automatic restart_frame();
        clr = 1'b1;
        tick("restart");
        clr = 1'b0;
    endtask

    int seen[60];
    int distinct;

    initial begin
        tbl[0] = '{0, 0, 0, 0};
        tbl[1] = '{1, 1, 2, 27};
        tbl[2] = '{2, 2, 4, 54};
        tbl[3] = '{0, 3, 1, 16};
        tbl[4] = '{1, 0, 3, 23};

        // Reset, then clr held: everything stays at zero
        t = 0;
        set_cfg(3, 4, 5, 2, 1);
        rst_n = 1'b0;
        clr   = 1'b1;
        #3;
        check_triple("reset", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick("clr_hold");

        // Release clr: known five-triple table
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_triple("seq0", tbl[0].e1, tbl[0].e2, tbl[0].e3);
`ifdef PFA_ADDR_LINEAR_EN
        check("seq0.addr_tbl", int'(addr), tbl[0].ea);
`endif
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check_triple($sformatf("seq%0d", i), tbl[i].e1, tbl[i].e2, tbl[i].e3);
`ifdef PFA_ADDR_LINEAR_EN
            check($sformatf("seq%0d.addr_tbl", i), int'(addr), tbl[i].ea);
`endif
        end

        // Full frame twice: model check plus permutation coverage of frame 1
        t = 4;
        restart_frame();
        for (int i = 0; i < 60; i++) seen[i] = 0;
        distinct = 0;
        for (int c = 0; c < 120; c++) begin
            if (c < 60) begin
                int a;
                a = int'(n1) * 20 + int'(n2) * 5 + int'(n3);
                if (a < 60 && seen[a] == 0) begin
                    seen[a] = 1;
                    distinct++;
                end
            end
            tick("frame");
        end
        check("frame.distinct", distinct, 60);
        check_triple("frame.wrap_end", 0, 0, 0);

        // Mid-frame clr pulse at cycle 17
        restart_frame();
        for (int c = 0; c < 17; c++) tick("pre_clr");
        clr = 1'b1;
        tick("midclr");
        check_triple("midclr.zero", 0, 0, 0);
        clr = 1'b0;
        tick("midclr.resume");
        check_triple("midclr.first", 1, 1, 2);

        // Mid-frame async reset at cycle 30, between edges
        restart_frame();
        for (int c = 0; c < 30; c++) tick("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        t = 0;
        check_triple("arst.immediate", 0, 0, 0);
        @(negedge clk);
        check_triple("arst.held", 0, 0, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) tick("arst.resume");

        // Degenerate factor Nf1 = 1: n1 pinned at zero, frame of 20
        set_cfg(1, 4, 5, 1, 1);
        restart_frame();
        for (int c = 0; c < 45; c++) begin
            tick("degen");
            check("degen.n1_zero", int'(n1), 0);
        end
        t = 0;
        restart_frame();
        for (int c = 0; c < 20; c++) tick("degen.wrap");
        check_triple("degen.at20", 0, 0, 0);

        // Random configurations and random clr pulses against the closed-form model
        for (int r = 0; r < 12; r++) begin
            int a, b, c;
            a = int'($urandom_range(1, 12));
            b = int'($urandom_range(1, 12));
            c = int'($urandom_range(1, 12));
            set_cfg(a, b, c, int'($urandom_range(0, c - 1)), int'($urandom_range(0, b - 1)));
            restart_frame();
            for (int s = 0; s < 300; s++) begin
                clr = ($urandom_range(0, 49) == 0);
                tick("rand");
            end
            clr = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
